// File: rtl/aes_encrypt_core.sv
// aes_encrypt_core: iterative AES-128 encryption datapath.
//   One plaintext block is accepted through a valid/ready handshake. The core
//   then applies round keys 0..10, one round every two cycles. Each round key
//   is fetched from the upstream key memory through round_rd_out. The
//   ciphertext is handed to the consumer through a valid/ready handshake.
// Ports:
//   clk_in, rst_in            clock, synchronous active-high reset
//   key_expanded_in           key memory holds valid round keys
//   round_rd_out[3:0]         registered round index driven to the key memory
//   round_key_in[127:0]       round key returned by the key memory
//   pt_in/pt_valid_in/pt_ready_out   plaintext handshake
//   ct_out/ct_valid_out/ct_ready_in  ciphertext handshake
// Blocks are row-major: state byte s[r][c] occupies bits [127-8*(4r+c) -: 8].

// One S-box lane: a combinational 256-entry ROM.
module aes_sbox (
   input  logic [7:0] i_byte,
   output logic [7:0] o_byte
);
   localparam logic [0:255][7:0] SBOX = {
      128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};
   assign o_byte = SBOX[i_byte];
endmodule

module aes_encrypt_core (
   input  logic         clk_in,
   input  logic         rst_in,
   input  logic         key_expanded_in,
   output logic [3:0]   round_rd_out,
   input  logic [127:0] round_key_in,
   input  logic [127:0] pt_in,
   input  logic         pt_valid_in,
   output logic         pt_ready_out,
   output logic [127:0] ct_out,
   output logic         ct_valid_out,
   input  logic         ct_ready_in
);
   localparam logic [3:0] LAST = 4'd10;

   // Element 0 is the most significant byte, so byte k maps to s[k/4][k%4].
   typedef logic [0:15][7:0] blk_t;
   typedef enum logic [1:0] {S_IDLE, S_FETCH, S_ROUND, S_DONE} state_t;

   state_t         r_state;
   logic [3:0]     r_round;
   logic [127:0]   r_data;
   logic [127:0]   r_ct;
   logic           r_ct_valid;

   blk_t           w_st, w_sb, w_sr, w_mc;
   logic [127:0]   w_rnd;

   function automatic logic [7:0] xt(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   assign w_st = r_data;

   for (genvar g = 0; g < 16; g++) begin : g_lane
      aes_sbox u_sbox (.i_byte(w_st[g]), .o_byte(w_sb[g]));
   end

   always_comb begin
      w_sr = '0;
      w_mc = '0;
      // ShiftRows: row r rotates left by r bytes.
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++)
            w_sr[4*r+c] = w_sb[4*r+((c+r)%4)];
      // MixColumns on each column {s0,s1,s2,s3} = bytes c, 4+c, 8+c, 12+c.
      for (int c = 0; c < 4; c++) begin
         w_mc[c]    = xt(w_sr[c]) ^ xt(w_sr[4+c]) ^ w_sr[4+c] ^ w_sr[8+c] ^ w_sr[12+c];
         w_mc[4+c]  = w_sr[c] ^ xt(w_sr[4+c]) ^ xt(w_sr[8+c]) ^ w_sr[8+c] ^ w_sr[12+c];
         w_mc[8+c]  = w_sr[c] ^ w_sr[4+c] ^ xt(w_sr[8+c]) ^ xt(w_sr[12+c]) ^ w_sr[12+c];
         w_mc[12+c] = xt(w_sr[c]) ^ w_sr[c] ^ w_sr[4+c] ^ w_sr[8+c] ^ xt(w_sr[12+c]);
      end
      if (r_round == 4'd0)      w_rnd = r_data ^ round_key_in;
      else if (r_round == LAST) w_rnd = w_sr ^ round_key_in;
      else                      w_rnd = w_mc ^ round_key_in;
   end

   // Ready is combinational on key_expanded_in and is forced low while reset is asserted.
   assign pt_ready_out = (r_state == S_IDLE) && key_expanded_in && !rst_in;
   assign round_rd_out = r_round;
   assign ct_out       = r_ct;
   assign ct_valid_out = r_ct_valid;

   // FETCH is a dead cycle. It gives a registered key memory time to return the key.
   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         r_state    <= S_IDLE;
         r_round    <= '0;
         r_data     <= '0;
         r_ct       <= '0;
         r_ct_valid <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: if (pt_valid_in && pt_ready_out) begin
               r_data  <= pt_in;
               r_round <= '0;
               r_state <= S_FETCH;
            end
            S_FETCH: r_state <= S_ROUND;
            S_ROUND: begin
               r_data <= w_rnd;
               if (r_round == LAST) begin
                  r_ct       <= w_rnd;
                  r_ct_valid <= 1'b1;
                  r_state    <= S_DONE;
               end else begin
                  r_round <= r_round + 4'd1;
                  r_state <= S_FETCH;
               end
            end
            S_DONE: if (ct_ready_in) begin
               r_ct_valid <= 1'b0;
               r_state    <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end
endmodule
